// File: rtl/pipe_stage_reg_if.sv
// Handshaked bundle channel for pipe_stage_reg: upstream side, downstream side,
// flush and status. The stage uses the slave view; its environment uses master.
interface pipe_stage_reg_if #(
  parameter int PC_W    = 32,
  parameter int DATA_W  = 32,
  parameter int INSTR_W = 32,
  parameter int CTRL_W  = 22,
  parameter int CNT_W   = 16
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [DATA_W-1:0]  in_alu;
  logic [DATA_W-1:0]  in_op2;
  logic [INSTR_W-1:0] in_instr;
  logic [CTRL_W-1:0]  in_ctrl;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [DATA_W-1:0]  out_alu;
  logic [DATA_W-1:0]  out_op2;
  logic [INSTR_W-1:0] out_instr;
  logic [CTRL_W-1:0]  out_ctrl;
  logic [1:0]         occupancy;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output flush, in_valid, in_pc, in_alu, in_op2, in_instr, in_ctrl, out_ready,
    input  in_ready, out_valid, out_pc, out_alu, out_op2, out_instr, out_ctrl,
           occupancy, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_pc, in_alu, in_op2, in_instr, in_ctrl, out_ready,
    output in_ready, out_valid, out_pc, out_alu, out_op2, out_instr, out_ctrl,
           occupancy, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic handshaked pipeline stage register: optional 2-entry skid buffer,
// flush with bubble masking, and a saturating stall-cycle counter.
module pipe_stage_reg #(
  parameter int                 PC_W      = 32,
  parameter int                 DATA_W    = 32,
  parameter int                 INSTR_W   = 32,
  parameter int                 CTRL_W    = 22,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}},
  parameter bit                 SKID_EN   = 1'b1,
  parameter int                 CNT_W     = 16
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave bus
);
  localparam int BW       = PC_W + 2 * DATA_W + INSTR_W + CTRL_W;
  localparam int INSTR_LO = CTRL_W;
  localparam int OP2_LO   = INSTR_LO + INSTR_W;
  localparam int ALU_LO   = OP2_LO + DATA_W;
  localparam int PC_LO    = ALU_LO + DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } occ_e;

  logic [BW-1:0]    in_bundle_s;
  logic [BW-1:0]    main_r;
  logic [BW-1:0]    main_nxt_s;
  occ_e             occ_r;
  occ_e             occ_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic             out_valid_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             pop_s;

  assign in_bundle_s = {bus.in_pc, bus.in_alu, bus.in_op2, bus.in_instr, bus.in_ctrl};
  assign out_valid_s = (occ_r != EMPTY);
  assign accept_s    = bus.in_valid & in_ready_s;
  assign pop_s       = out_valid_s & bus.out_ready;

  if (SKID_EN) begin : g_skid
    logic [BW-1:0] skid_r;
    logic [BW-1:0] skid_nxt_s;
    logic          ready_r;

    // Next occupancy and data movement for the two-entry buffer
    always_comb begin
      main_nxt_s = main_r;
      skid_nxt_s = skid_r;
      occ_nxt_s  = occ_r;
      case (occ_r)
        EMPTY: begin
          if (accept_s) begin
            main_nxt_s = in_bundle_s;
            occ_nxt_s  = BUSY;
          end else begin
            occ_nxt_s  = EMPTY;
          end
        end
        BUSY: begin
          if (accept_s && pop_s) begin
            main_nxt_s = in_bundle_s;
          end else if (accept_s) begin
            skid_nxt_s = in_bundle_s;
            occ_nxt_s  = FULL;
          end else if (pop_s) begin
            occ_nxt_s  = EMPTY;
          end else begin
            occ_nxt_s  = BUSY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can happen
          if (pop_s) begin
            main_nxt_s = skid_r;
            occ_nxt_s  = BUSY;
          end else begin
            occ_nxt_s  = FULL;
          end
        end
        default: occ_nxt_s = EMPTY;
      endcase
    end

    // Skid storage and registered ready (no path from out_ready)
    always_ff @(posedge clk) begin
      if (!rst) begin
        skid_r  <= {BW{1'b0}};
        ready_r <= 1'b1;
      end else if (bus.flush) begin
        ready_r <= 1'b1;
      end else begin
        skid_r  <= skid_nxt_s;
        ready_r <= (occ_nxt_s != FULL);
      end
    end

    assign in_ready_s = ready_r;
  end else begin : g_single
    // Single entry: load on accept, drain on pop
    always_comb begin
      main_nxt_s = main_r;
      occ_nxt_s  = occ_r;
      if (accept_s) begin
        main_nxt_s = in_bundle_s;
        occ_nxt_s  = BUSY;
      end else if (pop_s) begin
        occ_nxt_s  = EMPTY;
      end else begin
        occ_nxt_s  = occ_r;
      end
    end

    assign in_ready_s = !out_valid_s | bus.out_ready;
  end

  // Occupancy state and main data; flush empties but keeps the data
  always_ff @(posedge clk) begin
    if (!rst) begin
      occ_r  <= EMPTY;
      main_r <= {BW{1'b0}};
    end else if (bus.flush) begin
      occ_r  <= EMPTY;
    end else begin
      occ_r  <= occ_nxt_s;
      main_r <= main_nxt_s;
    end
  end

  // Saturating stall counter, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (out_valid_s && !bus.out_ready && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_pc    = main_r[PC_LO +: PC_W];
  assign bus.out_alu   = main_r[ALU_LO +: DATA_W];
  assign bus.out_op2   = main_r[OP2_LO +: DATA_W];
  assign bus.out_instr = out_valid_s ? main_r[INSTR_LO +: INSTR_W] : NOP_INSTR;
  assign bus.out_ctrl  = out_valid_s ? main_r[0 +: CTRL_W] : {CTRL_W{1'b0}};
  assign bus.occupancy = occ_r;
  assign bus.stall_cnt = cnt_r;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (skid, skid with 4-bit counter,
// single entry) checked against a queue-based reference model.
module tb_pipe_stage_reg;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] op2;
    logic [31:0] instr;
    logic [21:0] ctrl;
  } bundle_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model: index 0 = skid/16-bit, 1 = skid/4-bit, 2 = single entry
  bundle_t q[3][$];
  int      cnt[3];
  int      cmax[3] = '{65535, 15, 65535};

  pipe_stage_reg_if #(.PC_W(32), .DATA_W(32), .INSTR_W(32), .CTRL_W(22), .CNT_W(16)) ifa ();
  pipe_stage_reg_if #(.PC_W(32), .DATA_W(32), .INSTR_W(32), .CTRL_W(22), .CNT_W(4))  ifb ();
  pipe_stage_reg_if #(.PC_W(32), .DATA_W(32), .INSTR_W(32), .CTRL_W(22), .CNT_W(16)) ifc ();

  pipe_stage_reg #(.NOP_INSTR(NOP), .SKID_EN(1'b1), .CNT_W(16)) u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  pipe_stage_reg #(.NOP_INSTR(NOP), .SKID_EN(1'b1), .CNT_W(4))  u_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  pipe_stage_reg #(.NOP_INSTR(NOP), .SKID_EN(1'b0), .CNT_W(16)) u_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  function automatic bundle_t rnd();
    bundle_t b;
    b.pc    = $urandom;
    b.alu   = $urandom;
    b.op2   = $urandom;
    b.instr = $urandom;
    b.ctrl  = 22'($urandom);
    return b;
  endfunction

  task automatic drive_a(input bit v, input bundle_t b, input bit ordy, input bit fl);
    ifa.in_valid = v; ifa.out_ready = ordy; ifa.flush = fl;
    ifa.in_pc = b.pc; ifa.in_alu = b.alu; ifa.in_op2 = b.op2; ifa.in_instr = b.instr; ifa.in_ctrl = b.ctrl;
  endtask

  task automatic drive_b(input bit v, input bundle_t b, input bit ordy, input bit fl);
    ifb.in_valid = v; ifb.out_ready = ordy; ifb.flush = fl;
    ifb.in_pc = b.pc; ifb.in_alu = b.alu; ifb.in_op2 = b.op2; ifb.in_instr = b.instr; ifb.in_ctrl = b.ctrl;
  endtask

  task automatic drive_c(input bit v, input bundle_t b, input bit ordy, input bit fl);
    ifc.in_valid = v; ifc.out_ready = ordy; ifc.flush = fl;
    ifc.in_pc = b.pc; ifc.in_alu = b.alu; ifc.in_op2 = b.op2; ifc.in_instr = b.instr; ifc.in_ctrl = b.ctrl;
  endtask

  // Reference: a FIFO of capacity 2 (or 1 with pass-through ready) per instance.
  task automatic model_edge(input int k, input bit iv, input bit ordy, input bit fl, input bundle_t bin);
    bit rdy;
    bit pop;
    if (!rst) begin
      q[k].delete();
      cnt[k] = 0;
      return;
    end
    rdy = (k == 2) ? (q[k].size() == 0 || ordy) : (q[k].size() < 2);
    pop = (q[k].size() > 0) && ordy;
    if (q[k].size() > 0 && !ordy && cnt[k] < cmax[k]) cnt[k]++;
    if (pop) void'(q[k].pop_front());
    if (iv && rdy) q[k].push_back(bin);
    if (fl) q[k].delete();
  endtask

  task automatic tick();
    model_edge(0, ifa.in_valid, ifa.out_ready, ifa.flush,
               bundle_t'({ifa.in_pc, ifa.in_alu, ifa.in_op2, ifa.in_instr, ifa.in_ctrl}));
    model_edge(1, ifb.in_valid, ifb.out_ready, ifb.flush,
               bundle_t'({ifb.in_pc, ifb.in_alu, ifb.in_op2, ifb.in_instr, ifb.in_ctrl}));
    model_edge(2, ifc.in_valid, ifc.out_ready, ifc.flush,
               bundle_t'({ifc.in_pc, ifc.in_alu, ifc.in_op2, ifc.in_instr, ifc.in_ctrl}));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", ifa.out_valid); end
    n_checks++; if (ifa.occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d exp 0", ifa.occupancy); end
    n_checks++; if (ifa.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall got %0d exp 0", ifa.stall_cnt); end
    n_checks++; if (ifa.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", ifa.in_ready); end
    n_checks++; if (ifa.out_pc !== 32'h0 || ifa.out_alu !== 32'h0) begin n_fail++; $display("FAIL reset_data got pc %h alu %h exp 0", ifa.out_pc, ifa.out_alu); end
    n_checks++; if (ifa.out_instr !== NOP || ifa.out_ctrl !== 22'h0) begin n_fail++; $display("FAIL reset_bubble got instr %h ctrl %h exp %h 0", ifa.out_instr, ifa.out_ctrl, NOP); end
    n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_single got %b exp 1", ifc.in_ready); end
    rst = 1'b1;
  endtask

  task automatic test_stream();
    bundle_t b;
    for (int i = 0; i < 3; i++) begin
      b = rnd();
      b.pc = 32'h100 + 32'(4 * i);
      drive_a(1'b1, b, 1'b1, 1'b0);
      tick();
      n_checks++; if (ifa.out_valid !== 1'b1 || ifa.out_pc !== b.pc) begin n_fail++; $display("FAIL stream_pc%0d got v%b %h exp %h", i, ifa.out_valid, ifa.out_pc, b.pc); end
      n_checks++; if ({ifa.out_alu, ifa.out_op2, ifa.out_instr, ifa.out_ctrl} !== {b.alu, b.op2, b.instr, b.ctrl}) begin n_fail++; $display("FAIL stream_fields%0d got %h exp %h", i, {ifa.out_alu, ifa.out_op2, ifa.out_instr, ifa.out_ctrl}, {b.alu, b.op2, b.instr, b.ctrl}); end
      n_checks++; if (ifa.occupancy !== 2'd1 || ifa.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_occ%0d got occ %0d rdy %b exp 1 1", i, ifa.occupancy, ifa.in_ready); end
    end
    drive_a(1'b0, rnd(), 1'b1, 1'b0);
    tick();
    n_checks++; if (ifa.occupancy !== 2'd0) begin n_fail++; $display("FAIL stream_drain got %0d exp 0", ifa.occupancy); end
  endtask

  task automatic test_backpressure();
    bundle_t b;
    b = rnd(); b.pc = 32'h200; drive_a(1'b1, b, 1'b1, 1'b0); tick();
    n_checks++; if (ifa.out_pc !== 32'h200) begin n_fail++; $display("FAIL bp_head got %h exp 200", ifa.out_pc); end
    b.pc = 32'h204; drive_a(1'b1, b, 1'b0, 1'b0); tick();
    n_checks++; if (ifa.occupancy !== 2'd2 || ifa.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got occ %0d rdy %b exp 2 0", ifa.occupancy, ifa.in_ready); end
    b.pc = 32'h208; drive_a(1'b1, b, 1'b0, 1'b0); tick(); tick();
    n_checks++; if (ifa.stall_cnt !== 16'd3) begin n_fail++; $display("FAIL bp_stall got %0d exp 3", ifa.stall_cnt); end
    n_checks++; if (ifa.out_pc !== 32'h200 || ifa.occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_hold got %h occ %0d exp 200 2", ifa.out_pc, ifa.occupancy); end
    drive_a(1'b1, b, 1'b1, 1'b0); tick();
    n_checks++; if (ifa.out_pc !== 32'h204 || ifa.occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_second got %h occ %0d exp 204 1", ifa.out_pc, ifa.occupancy); end
    tick();
    n_checks++; if (ifa.out_pc !== 32'h208 || ifa.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_third got %h v%b exp 208", ifa.out_pc, ifa.out_valid); end
    drive_a(1'b0, b, 1'b1, 1'b0); tick();
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got v%b exp 0", ifa.out_valid); end
  endtask

  task automatic test_flush();
    bundle_t b;
    b = rnd(); b.pc = 32'h280; drive_a(1'b1, b, 1'b0, 1'b0); tick();
    b.pc = 32'h284; drive_a(1'b1, b, 1'b0, 1'b0); tick();
    n_checks++; if (ifa.occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_pre got %0d exp 2", ifa.occupancy); end
    b.pc = 32'h300; drive_a(1'b1, b, 1'b0, 1'b1); tick();
    n_checks++; if (ifa.occupancy !== 2'd0 || ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_state got occ %0d v%b rdy %b exp 0 0 1", ifa.occupancy, ifa.out_valid, ifa.in_ready); end
    n_checks++; if (ifa.out_ctrl !== 22'h0 || ifa.out_instr !== NOP) begin n_fail++; $display("FAIL flush_bubble got ctrl %h instr %h exp 0 %h", ifa.out_ctrl, ifa.out_instr, NOP); end
    n_checks++; if (ifa.out_pc !== 32'h280) begin n_fail++; $display("FAIL flush_data_hold got %h exp 280", ifa.out_pc); end
    n_checks++; if (ifa.stall_cnt !== 16'(cnt[0])) begin n_fail++; $display("FAIL flush_stall got %0d exp %0d", ifa.stall_cnt, cnt[0]); end
    drive_a(1'b0, b, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_leak%0d got v%b pc %h exp 0", i, ifa.out_valid, ifa.out_pc); end
    end
  endtask

  task automatic test_saturation();
    drive_b(1'b1, rnd(), 1'b0, 1'b0); tick();
    drive_b(1'b0, rnd(), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    n_checks++; if (ifb.stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_value got %0d exp 15", ifb.stall_cnt); end
    tick();
    n_checks++; if (ifb.stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d exp 15", ifb.stall_cnt); end
    drive_b(1'b0, rnd(), 1'b0, 1'b1); tick();
    drive_b(1'b0, rnd(), 1'b0, 1'b0); tick();
    n_checks++; if (ifb.stall_cnt !== 4'd15 || ifb.out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_flush got %0d v%b exp 15 0", ifb.stall_cnt, ifb.out_valid); end
  endtask

  task automatic test_single();
    bundle_t b;
    b = rnd(); b.pc = 32'h400; drive_c(1'b1, b, 1'b0, 1'b0); tick();
    n_checks++; if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'h400) begin n_fail++; $display("FAIL single_load got v%b %h exp 400", ifc.out_valid, ifc.out_pc); end
    n_checks++; if (ifc.in_ready !== 1'b0) begin n_fail++; $display("FAIL single_block got %b exp 0", ifc.in_ready); end
    ifc.out_ready = 1'b1; #1;
    n_checks++; if (ifc.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_comb_ready got %b exp 1", ifc.in_ready); end
    b.pc = 32'h404; drive_c(1'b1, b, 1'b1, 1'b0); tick();
    n_checks++; if (ifc.out_pc !== 32'h404 || ifc.occupancy !== 2'd1) begin n_fail++; $display("FAIL single_swap got %h occ %0d exp 404 1", ifc.out_pc, ifc.occupancy); end
    drive_c(1'b0, b, 1'b1, 1'b0); tick();
    n_checks++; if (ifc.occupancy !== 2'd0) begin n_fail++; $display("FAIL single_drain got %0d exp 0", ifc.occupancy); end
  endtask

  task automatic test_reset_mid();
    bundle_t b;
    b = rnd(); b.pc = 32'h500; drive_a(1'b1, b, 1'b0, 1'b0); tick();
    b.pc = 32'h504; drive_a(1'b1, b, 1'b0, 1'b0); tick();
    n_checks++; if (ifa.occupancy !== 2'd2) begin n_fail++; $display("FAIL rmid_pre got %0d exp 2", ifa.occupancy); end
    b.pc = 32'h508; drive_a(1'b1, b, 1'b1, 1'b0);
    rst = 1'b0; tick(); rst = 1'b1;
    drive_a(1'b0, b, 1'b1, 1'b0);
    n_checks++; if (ifa.occupancy !== 2'd0 || ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_state got occ %0d v%b rdy %b exp 0 0 1", ifa.occupancy, ifa.out_valid, ifa.in_ready); end
    n_checks++; if (ifa.stall_cnt !== 16'd0 || ifb.stall_cnt !== 4'd0) begin n_fail++; $display("FAIL rmid_stall got %0d %0d exp 0 0", ifa.stall_cnt, ifb.stall_cnt); end
    n_checks++; if (ifa.out_pc !== 32'h0) begin n_fail++; $display("FAIL rmid_data got %h exp 0", ifa.out_pc); end
    tick();
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_lost got v%b pc %h exp 0", ifa.out_valid, ifa.out_pc); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive_a($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      drive_b($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);
      drive_c($urandom_range(0, 3) != 0, rnd(), $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        bit      ov;
        bit      rd;
        bit      ordy;
        bundle_t ob;
        int      oc;
        int      st;
        bit      exp_v;
        bit      exp_rd;
        case (k)
          0: begin ov = ifa.out_valid; rd = ifa.in_ready; ordy = ifa.out_ready; oc = int'(ifa.occupancy); st = int'(ifa.stall_cnt);
                   ob = {ifa.out_pc, ifa.out_alu, ifa.out_op2, ifa.out_instr, ifa.out_ctrl}; end
          1: begin ov = ifb.out_valid; rd = ifb.in_ready; ordy = ifb.out_ready; oc = int'(ifb.occupancy); st = int'(ifb.stall_cnt);
                   ob = {ifb.out_pc, ifb.out_alu, ifb.out_op2, ifb.out_instr, ifb.out_ctrl}; end
          default: begin ov = ifc.out_valid; rd = ifc.in_ready; ordy = ifc.out_ready; oc = int'(ifc.occupancy); st = int'(ifc.stall_cnt);
                   ob = {ifc.out_pc, ifc.out_alu, ifc.out_op2, ifc.out_instr, ifc.out_ctrl}; end
        endcase
        exp_v  = q[k].size() > 0;
        exp_rd = (k == 2) ? (q[k].size() == 0 || ordy) : (q[k].size() < 2);
        n_checks++; if (ov !== exp_v || oc != q[k].size()) begin n_fail++; $display("FAIL rand_occ dut%0d cyc%0d got v%b occ %0d exp v%b occ %0d", k, n, ov, oc, exp_v, q[k].size()); end
        n_checks++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rand_ready dut%0d cyc%0d got %b exp %b", k, n, rd, exp_rd); end
        n_checks++; if (st != cnt[k]) begin n_fail++; $display("FAIL rand_stall dut%0d cyc%0d got %0d exp %0d", k, n, st, cnt[k]); end
        if (exp_v) begin
          n_checks++; if (ob !== q[k][0]) begin n_fail++; $display("FAIL rand_data dut%0d cyc%0d got %h exp %h", k, n, ob, q[k][0]); end
        end else begin
          n_checks++; if (ob.instr !== NOP || ob.ctrl !== 22'h0) begin n_fail++; $display("FAIL rand_bubble dut%0d cyc%0d got %h %h exp %h 0", k, n, ob.instr, ob.ctrl, NOP); end
        end
      end
    end
  endtask

  initial begin
    drive_a(1'b0, bundle_t'(0), 1'b0, 1'b0);
    drive_b(1'b0, bundle_t'(0), 1'b0, 1'b0);
    drive_c(1'b0, bundle_t'(0), 1'b0, 1'b0);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_saturation();
    test_single();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
